// File: rtl/otter_hazard_ctrl_p.sv
// otter_hazard_ctrl_p
// Hazard and forwarding controller for the pipelined OTTER core.
// An in-flight scoreboard covers EX (entry 1), MEM_LAT memory stages and
// WB (entry D = MEM_LAT+2). Its contents drive:
//   - forwarding selects,
//   - load-use and multi-cycle stalls,
//   - branch-redirect flushes, with a down-counted fetch-recovery shadow.
// Optional build macro HAZARD_PERF_EN adds three 32-bit event counters
// (load-use stall cycles, redirect events, ex_busy cycles).
// Every output except sb_valid is combinational from scoreboard state and
// the DE inputs. All outputs are forced low while RESET is held.

module otter_hazard_ctrl_p #(
   parameter int MEM_LAT   = 1,
   parameter int FETCH_LAT = 1,
   parameter int FWD_W     = $clog2(MEM_LAT + 3)
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               de_valid,
   input  logic [4:0]         de_rs1_addr,
   input  logic               de_rs1_used,
   input  logic [4:0]         de_rs2_addr,
   input  logic               de_rs2_used,
   input  logic [4:0]         de_rd_addr,
   input  logic               de_reg_write,
   input  logic               de_is_load,
   input  logic               ex_busy,
   input  logic               ex_redirect,
   output logic               stall_pc,
   output logic               bubble_ex,
   output logic               flush_de,
   output logic [FWD_W-1:0]   fwd_sel_a,
   output logic [FWD_W-1:0]   fwd_sel_b,
   output logic [MEM_LAT+1:0] sb_valid
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt,
   output logic [31:0]        perf_busy_cnt
`endif
);

   localparam int D = MEM_LAT + 2;

   // Scoreboard storage. Bit/index i holds stage k = i+1 (0 = EX, D-1 = WB).
   logic [D-1:0]      sb_v;
   logic [D-1:0]      sb_wr;
   logic [D-1:0]      sb_ld;
   logic [D-1:0][4:0] sb_rd;

   // Fetch-recovery down-counter. Two bits cover FETCH_LAT values 0..3.
   logic [1:0]        rec_cnt;
   logic              recovering;

   logic              hit_a;
   logic              hit_b;
   logic              ld_wait_a;
   logic              ld_wait_b;
   logic [FWD_W-1:0]  sel_a;
   logic [FWD_W-1:0]  sel_b;
   logic              load_use;
   logic              redirect_go;
   logic              ins_ok;

   assign recovering  = (rec_cnt != 2'd0);
   assign redirect_go = ex_redirect & ~ex_busy;

   // Youngest-match search per source operand. The loop walks from WB toward
   // EX, so the lowest matching stage is assigned last and wins. The check
   // rs != 0 also excludes any write to x0, because rd must equal rs.
   always_comb begin
      hit_a     = 1'b0;
      hit_b     = 1'b0;
      ld_wait_a = 1'b0;
      ld_wait_b = 1'b0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = D - 1; i >= 0; i--) begin
         if (sb_v[i] && sb_wr[i] && de_rs1_used && (de_rs1_addr != 5'd0) &&
             (sb_rd[i] == de_rs1_addr)) begin
            hit_a     = 1'b1;
            sel_a     = FWD_W'(i + 1);
            ld_wait_a = sb_ld[i] && (i != D - 1);
         end
         if (sb_v[i] && sb_wr[i] && de_rs2_used && (de_rs2_addr != 5'd0) &&
             (sb_rd[i] == de_rs2_addr)) begin
            hit_b     = 1'b1;
            sel_b     = FWD_W'(i + 1);
            ld_wait_b = sb_ld[i] && (i != D - 1);
         end
      end
   end

   assign load_use = de_valid & (ld_wait_a | ld_wait_b);

   // Stall, bubble, flush and forwarding decisions.
   // Priority: ex_busy first, then a redirect, then a load-use stall.
   always_comb begin
      stall_pc  = 1'b0;
      bubble_ex = 1'b0;
      flush_de  = 1'b0;
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      if (RESET) begin
         stall_pc  = ex_busy | (load_use & ~redirect_go);
         bubble_ex = ~ex_busy & (load_use | redirect_go);
         flush_de  = redirect_go | recovering;
         if (de_valid && !load_use) begin
            fwd_sel_a = hit_a ? sel_a : '0;
            fwd_sel_b = hit_b ? sel_b : '0;
         end
      end
   end

   // The DE instruction enters EX only when it is neither bubbled nor flushed.
   assign ins_ok = de_valid & ~bubble_ex & ~flush_de;

   // Scoreboard advance: shift toward WB unless EX is busy; the WB entry
   // falls off the end.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sb_v  <= '0;
         sb_wr <= '0;
         sb_ld <= '0;
         sb_rd <= '0;
      end else if (!ex_busy) begin
         sb_v  <= {sb_v[D-2:0],  ins_ok};
         sb_wr <= {sb_wr[D-2:0], de_reg_write};
         sb_ld <= {sb_ld[D-2:0], de_is_load};
         sb_rd <= {sb_rd[D-2:0], de_rd_addr};
      end
   end

   // Fetch-recovery shadow. A redirect (re)loads FETCH_LAT. The counter then
   // counts down on non-busy cycles and holds while EX is busy.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rec_cnt <= 2'd0;
      end else if (redirect_go) begin
         rec_cnt <= 2'(FETCH_LAT);
      end else if (!ex_busy && recovering) begin
         rec_cnt <= rec_cnt - 2'd1;
      end
   end

   assign sb_valid = sb_v;

`ifdef HAZARD_PERF_EN
   // Event counters. They wrap naturally at 2^32.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
         perf_busy_cnt  <= 32'd0;
      end else begin
         if (load_use && !ex_busy && !redirect_go) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_go) perf_flush_cnt <= perf_flush_cnt + 32'd1;
         if (ex_busy) perf_busy_cnt <= perf_busy_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/otter_hazard_ctrl_p.md
Name: otter_hazard_ctrl_p

Overview:
- Parametrised hazard and forwarding controller for the pipelined OTTER core.
- Replaces the combinational load-use/flush logic with an in-flight scoreboard covering EX, a configurable number of memory stages, and WB.
- Generates the following from per-stage valid/rd/write/load state:
  - forwarding selects;
  - load-use and multi-cycle stalls;
  - branch-redirect flushes with a counted fetch-recovery shadow.

Parameters:
- MEM_LAT, 1, number of memory pipeline stages between EX and WB (1..4); scoreboard depth D = MEM_LAT+2.
- FETCH_LAT, 1, cycles after a redirect during which fetched words are invalid (0..3).
- FWD_W, $clog2(MEM_LAT+3), width of forwarding select.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous reset, active low
- de_valid  in  1  DE holds a real instruction
- de_rs1_addr  in  5  DE source 1
- de_rs1_used  in  1  DE reads rs1
- de_rs2_addr  in  5  DE source 2
- de_rs2_used  in  1  DE reads rs2
- de_rd_addr  in  5  DE destination
- de_reg_write  in  1  DE writes rd
- de_is_load  in  1  DE is a load
- ex_busy  in  1  multi-cycle EX op not done; freezes whole pipe
- ex_redirect  in  1  branch/jump taken, resolved in EX
- stall_pc  out  1  hold PC and IF/DE register
- bubble_ex  out  1  insert NOP into DE/EX register
- flush_de  out  1  zero IF/DE instruction
- fwd_sel_a  out  FWD_W  rs1 source: 0 = regfile, k = scoreboard stage k (1 = EX ... D = WB)
- fwd_sel_b  out  FWD_W  rs2 source, same encoding
- sb_valid  out  D  per-stage valid, for debug

Behaviour:
- Reset (RESET=0, async): all scoreboard entries invalid, recovery counter 0, all outputs 0.
- Scoreboard:
  - D entries {valid, rd, wr, load}; entry 1 = EX, entry D = WB.
  - Each cycle with ex_busy=0, entries shift toward WB.
  - Entry 1 is loaded with the DE instruction, or with invalid when bubble_ex or flush applies.
  - Entry D is retired.
  - With ex_busy=1, all entries hold.
- Writes by or to rd=x0 never match any comparison.
- Match rule: stage k matches rsN when valid & wr & rd==rsN & rsN_used & rsN!=0. The youngest match (lowest k) wins.
- Ready rule: a match is ready if not load, or if load and k==D (data in WB).
- Forwarding: fwd_sel = k of the youngest match when it is ready, else 0.
- Load-use stall:
  - Condition: any youngest match not ready, with de_valid=1.
  - Response: stall_pc=1, bubble_ex=1, fwd_sel outputs 0.
  - Condition re-evaluated every cycle; stall lasts exactly until the load reaches WB.
- Multi-cycle stall: ex_busy=1 -> stall_pc=1, bubble_ex=0, scoreboard frozen. ex_busy has priority over load-use.
- Redirect (ex_redirect=1 and ex_busy=0):
  - Same cycle: flush_de=1, bubble_ex=1, stall_pc=0.
  - Recovery counter loads FETCH_LAT.
  - While counter>0: flush_de=1; counter decrements each non-busy cycle.
  - Redirect overrides any concurrent load-use stall (the stalled instruction is squashed).
  - A redirect while counter>0 reloads the counter to FETCH_LAT.
- Redirect with ex_busy=1: ignored until ex_busy drops, and must be held by the source.
- de_valid=0: no stall, fwd_sel 0, entry 1 invalid.
- All outputs except sb_valid are combinational from scoreboard state and DE inputs. Latency from DE to forwarding decision is 0 cycles.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0], perf_flush_cnt[31:0], perf_busy_cnt[31:0]:
  - perf_stall_cnt counts load-use stall cycles;
  - perf_flush_cnt counts redirect events;
  - perf_busy_cnt counts ex_busy cycles.
  - Counters wrap at 2^32 and clear on reset.
- HAZARD_PERF_EN undefined: ports and counters absent.

Test Plan:
- MEM_LAT=1, add x5 in EX, DE reads rs1=x5 -> fwd_sel_a=1, no stall; next cycle, with DE reading x5 again -> fwd_sel_a=2.
- lw x6 in EX, DE add reads rs2=x6:
  - stall_pc=1 and bubble_ex=1 for exactly 2 cycles (MEM_LAT=1);
  - then fwd_sel_b=3, stall drops.
  - With MEM_LAT=3: exactly 4 stall cycles.
- Two in-flight writes to x7 at stages 1 and 2, DE reads x7 -> fwd_sel_a=1 (youngest). Write to x0 at stage 1, DE reads x0 -> fwd_sel_a=0.
- ex_redirect pulse with FETCH_LAT=2 -> flush_de high 3 consecutive cycles, bubble_ex high 1 cycle; second redirect during recovery -> counter reloads, flush extends.
- ex_busy high 5 cycles during load-use stall -> sb_valid unchanged, stall_pc=1 throughout, bubble_ex=0; load-use resolves after busy drops.
- Assert RESET mid-stall -> all outputs 0 immediately (async); with HAZARD_PERF_EN, counters read 0.
